// File: rtl/fp32_cmp_pipe.sv
// Multi-lane IEEE-754 binary32 comparator with a runtime-selected predicate and a
// bubble-collapsing valid/ready pipeline. Define FP32_CMP_FTZ_EN to flush denormals to signed zero.
module fp32_cmp_pipe #(
  parameter int LANES   = 4,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [2:0]           in_op,
  input  logic [LANES*32-1:0]  in_a,
  input  logic [LANES*32-1:0]  in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [LANES-1:0]     out_result,
  output logic [LANES-1:0]     out_unord,
  output logic [TAG_W-1:0]     out_tag
);

  // Returns {unord, lt, eq}; lt/eq describe the ordered relation and are masked later when unord.
  function automatic logic [2:0] cmp_lane(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a;
    logic [31:0] b;
    logic        nan_a;
    logic        nan_b;
    logic        lt;
    logic        eq;
    nan_a = (a_in[30:23] == 8'hFF) && (a_in[22:0] != 23'd0);
    nan_b = (b_in[30:23] == 8'hFF) && (b_in[22:0] != 23'd0);
    a = a_in;
    b = b_in;
`ifdef FP32_CMP_FTZ_EN
    if (a_in[30:23] == 8'h00) a = {a_in[31], 31'd0};
    if (b_in[30:23] == 8'h00) b = {b_in[31], 31'd0};
`endif
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      lt = 1'b0;
      eq = 1'b1;
    end else if (a[31] != b[31]) begin
      lt = a[31];
      eq = 1'b0;
    end else if (!a[31]) begin
      lt = a[30:0] < b[30:0];
      eq = a[30:0] == b[30:0];
    end else begin
      lt = a[30:0] > b[30:0];
      eq = a[30:0] == b[30:0];
    end
    return {nan_a | nan_b, lt, eq};
  endfunction

  function automatic logic [LANES-1:0] decode(input logic [2:0] op, input logic [LANES-1:0] lt,
                                              input logic [LANES-1:0] eq, input logic [LANES-1:0] un);
    logic [LANES-1:0] r;
    case (op)
      3'd0:    r = ~un & lt;
      3'd1:    r = ~un & (lt | eq);
      3'd2:    r = ~un & ~lt & ~eq;
      3'd3:    r = ~un & ~lt;
      3'd4:    r = ~un & eq;
      3'd5:    r = un | ~eq;
      3'd6:    r = un;
      default: r = ~un;
    endcase
    return r;
  endfunction

  logic [LANES-1:0]   lt_c;
  logic [LANES-1:0]   eq_c;
  logic [LANES-1:0]   unord_c;
  logic [LANES-1:0]   res_c;
  logic [LANES-1:0]   res1_c;
  logic [LATENCY-1:0] load;

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LANES-1:0]   result_q [LATENCY];
  logic [LANES-1:0]   result_d [LATENCY];
  logic [LANES-1:0]   unord_q  [LATENCY];
  logic [LANES-1:0]   unord_d  [LATENCY];
  logic [TAG_W-1:0]   tag_q    [LATENCY];
  logic [TAG_W-1:0]   tag_d    [LATENCY];
  logic [2:0]         op0_q, op0_d;
  logic [LANES-1:0]   eq0_q, eq0_d;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign {unord_c[gi], lt_c[gi], eq_c[gi]} = cmp_lane(in_a[32*gi +: 32], in_b[32*gi +: 32]);
    end
  endgenerate

  assign res_c  = decode(in_op, lt_c, eq_c, unord_c);
  // With two or more stages, stage 0 carries raw lt bits in its result field and the op is decoded into stage 1.
  assign res1_c = decode(op0_q, result_q[0], eq0_q, unord_q[0]);

  // A stage can load when it or any stage downstream of it has a hole, or the output drains.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      load[i] = out_rdy;
      for (int j = i; j < LATENCY; j++) begin
        if (!valid_q[j]) load[i] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    op0_d   = op0_q;
    eq0_d   = eq0_q;
    for (int s = 0; s < LATENCY; s++) begin
      result_d[s] = result_q[s];
      unord_d[s]  = unord_q[s];
      tag_d[s]    = tag_q[s];
    end
    if (load[0]) begin
      valid_d[0] = in_vld;
      if (in_vld) begin
        tag_d[0]   = in_tag;
        unord_d[0] = unord_c;
        if (LATENCY >= 2) begin
          result_d[0] = lt_c;
          eq0_d       = eq_c;
          op0_d       = in_op;
        end else begin
          result_d[0] = res_c;
        end
      end
    end
    for (int s = 1; s < LATENCY; s++) begin
      if (load[s]) begin
        valid_d[s] = valid_q[s-1];
        if (valid_q[s-1]) begin
          tag_d[s]    = tag_q[s-1];
          unord_d[s]  = unord_q[s-1];
          result_d[s] = (s == 1) ? res1_c : result_q[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      op0_q   <= '0;
      eq0_q   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        result_q[s] <= '0;
        unord_q[s]  <= '0;
        tag_q[s]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      op0_q   <= op0_d;
      eq0_q   <= eq0_d;
      for (int s = 0; s < LATENCY; s++) begin
        result_q[s] <= result_d[s];
        unord_q[s]  <= unord_d[s];
        tag_q[s]    <= tag_d[s];
      end
    end
  end

  assign in_rdy     = load[0];
  assign out_vld    = valid_q[LATENCY-1];
  assign out_result = result_q[LATENCY-1];
  assign out_unord  = unord_q[LATENCY-1];
  assign out_tag    = tag_q[LATENCY-1];

endmodule
